// File: rtl/board_test_ctrl.sv
// Board bring-up controller: synchronises switches/buttons, debounces buttons,
// and drives LEDs / seven-segment data according to a four-mode selector.
module board_test_ctrl #(
  parameter int unsigned SW_W       = 32,
  parameter int unsigned BTN_N      = 6,
  parameter int unsigned DEB_CYCLES = 250000,
  parameter int unsigned WALK_DIV   = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW_W-1:0]   sw,
  input  logic [BTN_N-1:0]  btn,
  output logic [SW_W-1:0]   led,
  output logic [31:0]       disp_data,
  output logic              disp_en,
  output logic [1:0]        mode,
  output logic [7:0]        press_cnt
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
  localparam int unsigned DIV_W = (WALK_DIV > 1) ? $clog2(WALK_DIV) : 1;

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    FREEZE = 2'd1,
    WALK   = 2'd2,
    INVERT = 2'd3
  } mode_t;

  mode_t              r_state;
  mode_t              w_state_nxt;
  logic [SW_W-1:0]    r_sw_s1;
  logic [SW_W-1:0]    r_sw_s2;
  logic [BTN_N-1:0]   r_btn_s1;
  logic [BTN_N-1:0]   r_btn_s2;
  logic [BTN_N-1:0]   r_stable;
  logic [BTN_N-1:0]   r_press;
  logic [CNT_W-1:0]   r_deb_cnt [BTN_N];
  logic [SW_W-1:0]    r_snap;
  logic [SW_W-1:0]    r_walk;
  logic [DIV_W-1:0]   r_div;
  logic [SW_W-1:0]    w_led;
  logic [SW_W-1:0]    w_walk_rot;
  logic [7:0]         w_inc;

  // Two-flop synchronisers for all asynchronous inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= btn;
      r_btn_s2 <= r_btn_s1;
    end
  end

  // Per-button debounce; r_press is a one-cycle pulse following a 0->1 acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable <= '0;
      r_press  <= '0;
      for (int i = 0; i < int'(BTN_N); i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(BTN_N); i++) begin
        r_press[i] <= 1'b0;
        if (r_btn_s2[i] == r_stable[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
          r_stable[i]  <= ~r_stable[i];
          r_deb_cnt[i] <= '0;
          r_press[i]   <= ~r_stable[i];
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= PASS;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_press[1]) begin
      case (r_state)
        PASS:    w_state_nxt = FREEZE;
        FREEZE:  w_state_nxt = WALK;
        WALK:    w_state_nxt = INVERT;
        default: w_state_nxt = PASS;
      endcase
    end
  end

  always_comb begin
    w_led = r_sw_s2;
    case (r_state)
      FREEZE:  w_led = r_snap;
      WALK:    w_led = r_walk;
      INVERT:  w_led = ~r_sw_s2;
      default: w_led = r_sw_s2;
    endcase
  end

  // Rotate-left that degenerates to "hold" when SW_W is 1
  assign w_walk_rot = (r_walk << 1) | (r_walk >> (SW_W - 1));

  always_comb begin
    w_inc = '0;
    for (int i = 0; i < int'(BTN_N); i++) w_inc = w_inc + 8'(r_press[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led       <= '0;
      disp_data <= '0;
      disp_en   <= 1'b1;
      press_cnt <= '0;
      r_snap    <= '0;
      r_walk    <= SW_W'(1);
      r_div     <= '0;
    end else begin
      if (r_press[0]) disp_en <= ~disp_en;
      if (r_press[2]) r_snap  <= r_sw_s2;
      press_cnt <= press_cnt + w_inc;
      if (w_state_nxt == WALK && r_state != WALK) begin
        r_walk <= SW_W'(1);
        r_div  <= '0;
      end else if (r_state == WALK) begin
        if (r_div == DIV_W'(WALK_DIV - 1)) begin
          r_div  <= '0;
          r_walk <= w_walk_rot;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end
      led       <= w_led;
      disp_data <= 32'(w_led);
    end
  end

  assign mode = r_state;

endmodule

// File: doc/board_test_ctrl.md
BOARD_TEST_CTRL -- requirements
Module: board_test_ctrl

Interface
REQ-001 SHALL have parameter SW_W, default 32, switch/LED width, legal range 1..32.
REQ-002 SHALL have parameter BTN_N, default 6, button count, legal range 3..8.
REQ-003 SHALL have parameter DEB_CYCLES, default 250000, cycles a raw button level must hold before acceptance, minimum 2.
REQ-004 SHALL have parameter WALK_DIV, default 25000000, clock cycles per running-light step, minimum 1.
REQ-005 SHALL have port clk  input  1  system clock; the only clock.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port sw  input  SW_W  switch levels, asynchronous to clk.
REQ-008 SHALL have port btn  input  BTN_N  raw push buttons, active-high, bouncing, asynchronous.
REQ-009 SHALL have port led  output  SW_W  LED drive, registered.
REQ-010 SHALL have port disp_data  output  32  data to seven-segment driver, registered.
REQ-011 SHALL have port disp_en  output  1  seven-segment enable, registered.
REQ-012 SHALL have port mode  output  2  current mode, registered.
REQ-013 SHALL have port press_cnt  output  8  count of accepted presses, registered.

Function
REQ-014 SHALL pass each btn bit and all sw bits through a two-flop synchroniser before any use.
REQ-015 SHALL per button keep a stable level and counter: counter clears whenever the synchronised level equals the stable level, otherwise increments; on reaching DEB_CYCLES-1 the stable level flips and the counter clears.
REQ-016 SHALL generate a one-cycle press pulse in the cycle a stable level goes 0->1; 1->0 transitions generate nothing.
REQ-017 SHALL on btn[0] press toggle disp_en in the following cycle.
REQ-018 SHALL on btn[1] press advance mode PASS(0)->FREEZE(1)->WALK(2)->INVERT(3)->PASS(0), wrapping 3->0.
REQ-019 SHALL on btn[2] press load snap register with the synchronised sw value of the pulse cycle, in any mode.
REQ-020 SHALL ignore presses of btn[BTN_N-1:3] except for press_cnt.
REQ-021 SHALL increment press_cnt by the number of press pulses in a cycle (0..BTN_N), modulo 256, wrapping 255->0.
REQ-022 SHALL apply simultaneous pulses on different buttons independently in the same cycle; btn[1] with btn[2] together: snapshot of current sw and mode advance both occur.
REQ-023 SHALL drive led, registered one cycle after inputs: PASS = synced sw; FREEZE = snap; WALK = walk register; INVERT = ~synced sw.
REQ-024 SHALL drive disp_data = led zero-extended to 32 bits, updated in the same cycle as led.
REQ-025 SHALL hold a one-hot walk register of SW_W bits and a divider counter; on entry to WALK both reset (walk = bit 0, divider = 0).
REQ-026 SHALL in WALK, when divider reaches WALK_DIV-1, clear divider and rotate walk left one bit, bit SW_W-1 wrapping to bit 0; SW_W=1 keeps bit 0 set.
REQ-027 SHALL freeze divider and walk register outside WALK.
REQ-028 SHALL keep disp_en independent of mode; disp_en=0 does not alter led or disp_data.

Reset
REQ-029 SHALL on rst high, immediately and regardless of clk: led=0, disp_data=0, disp_en=1, mode=0, press_cnt=0, snap=0, walk=1, all synchronisers, stable levels and counters 0.
REQ-030 SHALL on rst asserted mid-debounce or mid-walk discard all partial progress; a button held through reset release is accepted as a new press after DEB_CYCLES.

Verification (DEB_CYCLES=4, WALK_DIV=3, SW_W=8, BTN_N=6)
REQ-031 SHALL pass: sw=8'hA5 in PASS -> led=8'hA5, disp_data=32'h000000A5 within 3 clk.
REQ-032 SHALL pass: btn[0] bounces 1-0-1 over 3 cycles then holds high 10 cycles -> exactly one toggle, disp_en=0, press_cnt=1.
REQ-033 SHALL pass: sw=8'h3C, press btn[2], sw=8'h00, press btn[1] -> mode=1, led=8'h3C.
REQ-034 SHALL pass: enter WALK -> led 8'h01, 8'h02 ... 8'h80, 8'h01 every 3 cycles; press btn[1] -> mode=3, led=~sw.
REQ-035 SHALL pass: btn[0], btn[1] and btn[5] rise together held 10 cycles -> disp_en toggles, mode advances, press_cnt +3; from 254 wraps to 1.
REQ-036 SHALL pass: assert rst mid-WALK asynchronously -> outputs take REQ-029 values before next clk edge.
